taint_sum_monitor: RTL
======================

TAINT_SUM_MONITOR -- requirements
Module: taint_sum_monitor

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8: number of taint_sum sources aggregated.
REQ-002 SHALL have parameter SUM_WIDTH, default 8: width of each source taint_sum lane.
REQ-003 SHALL have parameter CYC_WIDTH, default 32: cycle-stamp width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: event-record FIFO entries, power of two.
REQ-005 SHALL have derived localparam TOT_WIDTH = SUM_WIDTH + $clog2(NUM_SRC): total width.
REQ-006 SHALL have port clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port en  input  1  sampling enable; low freezes all state.
REQ-009 SHALL have port src_sum  input  NUM_SRC*SUM_WIDTH  packed taint_sum lanes, lane i at [i*SUM_WIDTH +: SUM_WIDTH], unsigned.
REQ-010 SHALL have port total  output  TOT_WIDTH  registered sum of all lanes.
REQ-011 SHALL have port max_total  output  TOT_WIDTH  peak total since reset.
REQ-012 SHALL have port cycle  output  CYC_WIDTH  count of enabled cycles.
REQ-013 SHALL have port first_valid  output  1 and first_cycle  output  CYC_WIDTH  cycle stamp of first nonzero total.
REQ-014 SHALL have port state  output  2  monitor state (CLEAN=0, TAINTED=1, DRAINED=2).
REQ-015 SHALL have ports rec_valid output 1, rec_ready input 1, rec_data output CYC_WIDTH+TOT_WIDTH ({cycle, total}).
REQ-016 SHALL have port drop_cnt  output  16  records lost to FIFO full.

Function
REQ-017 SHALL, on an edge with en=1, register total = unsigned sum of all lanes sampled that edge (1-cycle latency), no overflow possible by width.
REQ-018 SHALL, on an edge with en=1, increment cycle by 1, wrapping to 0 after all-ones; total, max_total and cycle SHALL hold when en=0.
REQ-019 SHALL update max_total = max(max_total, new total) on every en=1 edge.
REQ-020 SHALL run FSM: CLEAN->TAINTED when new total>0; TAINTED->DRAINED when new total==0; DRAINED->TAINTED when new total>0; no return to CLEAN except reset.
REQ-021 SHALL, on CLEAN->TAINTED, set first_valid=1 and first_cycle=cycle value stamped on that edge; neither changes again until reset.
REQ-022 SHALL push record {cycle, new total} when en=1 and new total differs from previous total; both fields equal the post-edge register values.
REQ-023 SHALL present FIFO head on rec_data with rec_valid=1 when non-empty; pop on rec_valid&rec_ready; rec_data stable while rec_valid&!rec_ready.
REQ-024 SHALL, when full with simultaneous push and pop, accept both (occupancy unchanged, no drop).
REQ-025 SHALL, when full with push and no pop, discard the new record and increment drop_cnt, saturating at 16'hFFFF.
REQ-026 SHALL keep FIFO pop operating when en=0 (draining is independent of en).

Reset
REQ-027 SHALL, on any edge with reset=1, set total=0, max_total=0, cycle=0, first_valid=0, first_cycle=0, state=CLEAN, drop_cnt=0, flush FIFO (rec_valid=0), overriding en, push and pop, including mid-operation.

Configuration
REQ-028 SHALL honour macro TAINT_SUM_MONITOR_LOG_EN: defined -> record FIFO, rec_* handshake and drop_cnt as above; undefined -> no FIFO instantiated, rec_valid and rec_data tied 0, rec_ready ignored, drop_cnt tied 0; all other behaviour identical.

Structure
REQ-029 SHALL place state encoding enum, record struct type and state localparams in shared package taint_mon_pkg.
REQ-030 SHALL implement the record FIFO as sub-module taint_mon_fifo (sync, single-clock, valid/ready pop, full/empty flags).

Verification
REQ-031 SHALL verify: reset, NUM_SRC=8, all lanes 0 for 10 en cycles -> total=0, state=CLEAN, cycle=10, rec_valid=0.
REQ-032 SHALL verify: lane2=5, lane7=3 at cycle 4 -> next edge total=8, state=TAINTED, first_cycle=5, record {5,8} pushed.
REQ-033 SHALL verify: lanes back to 0 -> total=0, state=DRAINED, max_total=8; lane0=1 later -> TAINTED, first_cycle still 5.
REQ-034 SHALL verify: rec_ready=0, total changing every cycle for 7 cycles, FIFO_DEPTH=4 -> 4 records held, drop_cnt=3, head unchanged.
REQ-035 SHALL verify: full FIFO, rec_ready=1 with new push -> occupancy 4, drop_cnt unchanged; en=0 with rec_ready=1 -> FIFO drains, cycle frozen.
REQ-036 SHALL verify: reset asserted mid-stream with FIFO holding 3 records -> next edge all outputs zero, state=CLEAN, rec_valid=0.

Source files
------------

// File: rtl/taint_mon_pkg.sv
// rtl/taint_mon_pkg.sv - shared state encoding and record layout for the taint-sum monitor
package taint_mon_pkg;

    localparam int STATE_W   = 2;
    localparam int REC_CYC_W = 32;
    localparam int REC_TOT_W = 11;

    typedef enum logic [STATE_W-1:0] {
        ST_CLEAN   = 2'd0,
        ST_TAINTED = 2'd1,
        ST_DRAINED = 2'd2
    } mon_state_e;

    // Record layout for the default parameterisation (CYC_WIDTH=32, TOT_WIDTH=11).
    typedef struct packed {
        logic [REC_CYC_W-1:0] cyc;
        logic [REC_TOT_W-1:0] tot;
    } taint_rec_t;

endpackage

// File: rtl/taint_mon_fifo.sv
// rtl/taint_mon_fifo.sv - single-clock record FIFO with valid/ready pop and full/empty flags
module taint_mon_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             pop;
    logic             wr_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop     = ready_i && !empty_o;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign wr_en   = push_i && (!full_o || pop);
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q[AW-1:0]] <= wdata_i;
                wr_q                <= wr_q + {{AW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/taint_sum_monitor.sv
// rtl/taint_sum_monitor.sv - taint_sum aggregator with peak/first-seen tracking; TAINT_SUM_MONITOR_LOG_EN adds record FIFO
module taint_sum_monitor
    import taint_mon_pkg::*;
#(
    parameter  int NUM_SRC    = 8,
    parameter  int SUM_WIDTH  = 8,
    parameter  int CYC_WIDTH  = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int TOT_WIDTH  = SUM_WIDTH + $clog2(NUM_SRC)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           en,
    input  logic [NUM_SRC*SUM_WIDTH-1:0]   src_sum,
    output logic [TOT_WIDTH-1:0]           total,
    output logic [TOT_WIDTH-1:0]           max_total,
    output logic [CYC_WIDTH-1:0]           cycle,
    output logic                           first_valid,
    output logic [CYC_WIDTH-1:0]           first_cycle,
    output logic [1:0]                     state,
    output logic                           rec_valid,
    input  logic                           rec_ready,
    output logic [CYC_WIDTH+TOT_WIDTH-1:0] rec_data,
    output logic [15:0]                    drop_cnt
);

    logic [TOT_WIDTH-1:0]           total_q, max_q, sum_d;
    logic [CYC_WIDTH-1:0]           cycle_q, cycle_d, first_cycle_q;
    logic                           first_valid_q;
    mon_state_e                     state_q;
    logic                           push_d;
    logic [CYC_WIDTH+TOT_WIDTH-1:0] rec_d;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum_d = sum_d + TOT_WIDTH'(src_sum[i*SUM_WIDTH +: SUM_WIDTH]);
        end
    end

    assign cycle_d = cycle_q + CYC_WIDTH'(1);
    // Records carry the post-edge values, so they match what total/cycle show next.
    assign push_d  = en && (sum_d != total_q);
    assign rec_d   = {cycle_d, sum_d};

    always_ff @(posedge clock) begin
        if (reset) begin
            total_q       <= '0;
            max_q         <= '0;
            cycle_q       <= '0;
            first_valid_q <= 1'b0;
            first_cycle_q <= '0;
            state_q       <= ST_CLEAN;
        end else if (en) begin
            total_q <= sum_d;
            cycle_q <= cycle_d;
            if (sum_d > max_q) begin
                max_q <= sum_d;
            end
            case (state_q)
                ST_CLEAN: if (sum_d != '0) begin
                    state_q       <= ST_TAINTED;
                    first_valid_q <= 1'b1;
                    first_cycle_q <= cycle_d;
                end
                ST_TAINTED: if (sum_d == '0) state_q <= ST_DRAINED;
                ST_DRAINED: if (sum_d != '0) state_q <= ST_TAINTED;
                default:    state_q <= ST_CLEAN;
            endcase
        end
    end

    assign total       = total_q;
    assign max_total   = max_q;
    assign cycle       = cycle_q;
    assign first_valid = first_valid_q;
    assign first_cycle = first_cycle_q;
    assign state       = state_q;

`ifdef TAINT_SUM_MONITOR_LOG_EN
    logic                           fifo_full, fifo_empty;
    logic [CYC_WIDTH+TOT_WIDTH-1:0] fifo_rdata;
    logic [15:0]                    drop_q;

    taint_mon_fifo #(
        .WIDTH (CYC_WIDTH + TOT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push_d),
        .wdata_i (rec_d),
        .ready_i (rec_ready),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_q <= '0;
        end else if (push_d && fifo_full && !rec_ready && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign rec_valid = !fifo_empty;
    assign rec_data  = fifo_empty ? '0 : fifo_rdata;
    assign drop_cnt  = drop_q;
`else
    logic unused_log;
    assign unused_log = ^{rec_ready, push_d, rec_d};
    assign rec_valid  = 1'b0;
    assign rec_data   = '0;
    assign drop_cnt   = '0;
`endif

endmodule
